lnet_input_packer: RTL

Streaming front-end that converts raw unsigned feature samples into the 2-bit quantized codes consumed by the layer-0 neuron LUTs, and assembles them into one packed input vector per inference. Features arrive one per handshake on an input stream. The packed vector is presented on a valid/ready output that feeds the registered input of the layer-0 neuron array. It is the producer side of the layer-0 M0 interface.

---
 rtl/lnet_input_packer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lnet_input_packer.sv
// lnet_input_packer
// Streaming front-end for the layer-0 neuron array. It quantizes each raw
// unsigned feature into a 2-bit code, using three ascending thresholds. It
// assembles NUM_FEATURES codes into one packed vector. The vector goes out on
// a valid/ready port.
//
// There are two stages: an assembly register and an output register. The
// next vector can therefore fill while the current one waits on m_ready.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   s_valid    feature sample valid
//   s_ready    packer accepts a sample this cycle
//   s_data     raw unsigned feature, FEAT_W bits
//   s_last     marks the final feature of a vector
//   m_valid    packed vector valid
//   m_ready    downstream accepts the vector
//   m_data     packed codes; feature i sits at bits [2i+1:2i]
//   err_frame  one-cycle pulse on a framing error
//   cfg_we / cfg_feat / cfg_sel / cfg_thresh
//              threshold table write port. These ports exist only when the
//              macro LNET_INPUT_PACKER_THRESH_PROG_EN is defined.
//
// Optional feature: LNET_INPUT_PACKER_THRESH_PROG_EN.
//   Defined:   each feature has its own programmable T0/T1/T2 entries.
//   Undefined: every feature compares against the THRESH parameter.
module lnet_input_packer #(
  parameter int unsigned         NUM_FEATURES = 8,
  parameter int unsigned         FEAT_W       = 8,
  // Packed as {T2, T1, T0}, each FEAT_W bits, ascending T0 <= T1 <= T2.
  parameter logic [3*FEAT_W-1:0] THRESH       = {8'd192, 8'd128, 8'd64}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_W-1:0]             s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [2*NUM_FEATURES-1:0]     m_data,
  output logic                          err_frame
`ifdef LNET_INPUT_PACKER_THRESH_PROG_EN
  ,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_FEATURES)-1:0] cfg_feat,
  input  logic [1:0]                    cfg_sel,
  input  logic [FEAT_W-1:0]             cfg_thresh
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic {StFill, StFull} state_e;

  state_e                      r_state;
  state_e                      w_state_next;
  logic [IDX_W-1:0]            r_idx;
  logic [IDX_W-1:0]            w_idx_next;
  logic [2*NUM_FEATURES-1:0]   r_asm;
  logic [2*NUM_FEATURES-1:0]   w_asm_next;
  logic [2*NUM_FEATURES-1:0]   w_asm_slot;
  logic                        r_m_valid;
  logic [2*NUM_FEATURES-1:0]   r_m_data;
  logic                        r_err;
  logic                        w_err_next;
  logic                        w_out_load;
  logic [2*NUM_FEATURES-1:0]   w_out_data;
  logic                        w_accept;
  logic                        w_last_slot;
  logic                        w_out_free;
  logic [FEAT_W-1:0]           w_t0;
  logic [FEAT_W-1:0]           w_t1;
  logic [FEAT_W-1:0]           w_t2;
  logic [1:0]                  w_code;

  // ---------------------------------------------------------------------------
  // Threshold source
  // ---------------------------------------------------------------------------
`ifdef LNET_INPUT_PACKER_THRESH_PROG_EN
  logic [FEAT_W-1:0] r_thr [NUM_FEATURES][3];

  // The table write lands at the edge. A sample accepted in the same cycle
  // therefore still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < int'(NUM_FEATURES); f++) begin
        for (int k = 0; k < 3; k++) begin
          r_thr[f][k] <= THRESH[k*FEAT_W +: FEAT_W];
        end
      end
    end else if (cfg_we && (cfg_sel != 2'd3) && (int'(cfg_feat) < int'(NUM_FEATURES))) begin
      r_thr[cfg_feat][cfg_sel] <= cfg_thresh;
    end
  end

  assign w_t0 = r_thr[r_idx][0];
  assign w_t1 = r_thr[r_idx][1];
  assign w_t2 = r_thr[r_idx][2];
`else
  assign w_t0 = THRESH[0*FEAT_W +: FEAT_W];
  assign w_t1 = THRESH[1*FEAT_W +: FEAT_W];
  assign w_t2 = THRESH[2*FEAT_W +: FEAT_W];
`endif

  // ---------------------------------------------------------------------------
  // Quantization and slot insertion
  // ---------------------------------------------------------------------------
  assign w_code = {1'b0, (s_data >= w_t0)} + {1'b0, (s_data >= w_t1)} +
                  {1'b0, (s_data >= w_t2)};

  always_comb begin
    w_asm_slot = r_asm;
    w_asm_slot[2*r_idx +: 2] = w_code;
  end

  // Gate with rst so that s_ready reads 0 while reset is held.
  assign s_ready     = (r_state == StFill) && !rst;
  assign w_accept    = s_valid && s_ready;
  assign w_last_slot = (r_idx == LAST_IDX);
  assign w_out_free  = !r_m_valid || m_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_asm_next   = r_asm;
    w_out_load   = 1'b0;
    w_out_data   = w_asm_slot;
    w_err_next   = 1'b0;
    unique case (r_state)
      StFill: begin
        if (w_accept) begin
          if (w_last_slot && s_last) begin
            w_asm_next = w_asm_slot;
            w_idx_next = '0;
            if (w_out_free) begin
              w_out_load = 1'b1;
              w_out_data = w_asm_slot;
            end else begin
              w_state_next = StFull;
            end
          end else if (w_last_slot || s_last) begin
            // Framing error: drop the sample and the partial vector.
            w_idx_next = '0;
            w_err_next = 1'b1;
          end else begin
            w_asm_next = w_asm_slot;
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      StFull: begin
        if (w_out_free) begin
          w_out_load   = 1'b1;
          w_out_data   = r_asm;
          w_state_next = StFill;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFill;
      r_idx   <= '0;
      r_asm   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_asm   <= w_asm_next;
      r_err   <= w_err_next;
    end
  end

  // A new vector may load on the same edge that the old one is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_out_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_out_data;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign err_frame = r_err;

endmodule
